// File: rtl/stack_arbiter_if.sv
// Requester/response bus between NUM_REQ requesters and the stack arbiter.
//   req_valid/req_op/req_data : per-requester operation request (master -> slave)
//   req_ready                 : one-hot grant (slave -> master)
//   rsp_valid/rsp_id/rsp_data/rsp_err : response, held until rsp_ready (slave -> master)
//   rsp_ready                 : response accept (master -> slave)
interface stack_arbiter_if #(
    parameter int NUM_REQ     = 2,
    parameter int STACK_WIDTH = 18
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_op;
    logic [NUM_REQ*STACK_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [ID_W-1:0]                rsp_id;
    logic [STACK_WIDTH-1:0]         rsp_data;
    logic                           rsp_err;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one circular LIFO among NUM_REQ requesters.
// Tracks occupancy so the stack pointer never wraps; full/empty ops are
// answered with rsp_err and no stack strobe.
//   clk, reset_n        : clock, async active-low reset
//   flush               : level request to empty the stack (honoured in IDLE)
//   bus (slave)         : request/grant and response handshake
//   stk_push/pop/reset  : strobes to the stack, stk_data_in its write data
//   stk_data_out        : stack read data, valid one cycle after stk_pop
//   count, full, empty  : occupancy
//
// state   | meaning
// FLUSH   | stk_reset pulse, occupancy cleared
// IDLE    | arbitrate, grant one requester
// EXEC    | one-cycle push or pop strobe
// CAPT    | capture popped word from the stack
// RESP    | hold response until rsp_ready
module stack_arbiter #(
    parameter int STACK_WIDTH = 18,
    parameter int STACK_SIZE  = 1,
    parameter int NUM_REQ     = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    stack_arbiter_if.slave         bus,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic                   stk_reset,
    output logic [STACK_WIDTH-1:0] stk_data_in,
    input  logic [STACK_WIDTH-1:0] stk_data_out,
    output logic [STACK_SIZE:0]    count,
    output logic                   full,
    output logic                   empty
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int DEPTH = 2 ** STACK_SIZE;

    typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_EXEC, S_CAPT, S_RESP} state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        last_grant;
    logic                   op_push;
    logic [ID_W-1:0]        rsp_id_q;
    logic [STACK_WIDTH-1:0] rsp_data_q;
    logic                   rsp_err_q;

    logic                   grant_found;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_go;
    logic                   grant_op;
    logic                   grant_err;

    assign full  = (count == (STACK_SIZE+1)'(DEPTH));
    assign empty = (count == '0);

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    assign grant_go  = (state == S_IDLE) && !flush && grant_found;
    assign grant_op  = bus.req_op[grant_id];
    assign grant_err = grant_op ? full : empty;

    assign bus.req_ready = grant_go ? (NUM_REQ'(1) << grant_id) : '0;
    assign bus.rsp_valid = (state == S_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    assign stk_reset = (state == S_FLUSH);
    assign stk_push  = (state == S_EXEC) &&  op_push;
    assign stk_pop   = (state == S_EXEC) && !op_push;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FLUSH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FLUSH: state_nxt = S_IDLE;
            S_IDLE: begin
                if (flush)            state_nxt = S_FLUSH;
                else if (grant_found) state_nxt = grant_err ? S_RESP : S_EXEC;
            end
            S_EXEC:  state_nxt = op_push ? S_RESP : S_CAPT;
            S_CAPT:  state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            last_grant  <= ID_W'(NUM_REQ-1);
            op_push     <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            stk_data_in <= '0;
        end else begin
            case (state)
                S_FLUSH: count <= '0;
                S_IDLE: begin
                    if (grant_go) begin
                        last_grant  <= grant_id;
                        op_push     <= grant_op;
                        rsp_id_q    <= grant_id;
                        stk_data_in <= bus.req_data[int'(grant_id)*STACK_WIDTH +: STACK_WIDTH];
                        rsp_err_q   <= grant_err;
                        rsp_data_q  <= '0;
                    end
                end
                S_EXEC: begin
                    if (op_push) begin
                        count      <= count + 1'b1;
                        rsp_data_q <= '0;
                    end else begin
                        count      <= count - 1'b1;
                    end
                end
                S_CAPT:  rsp_data_q <= stk_data_out;
                default: ;
            endcase
        end
    end
endmodule
